// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives the Icache request and
// buffers hit instructions in a small circular FIFO toward decode.
module fetch_stage #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    INST_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 2,
    parameter int                    LOG_FIFO_DEPTH = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  icache_enable,
    input  logic [INST_WIDTH-1:0] icache_inst,
    input  logic                  icache_valid,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  dec_fault
);

    typedef enum logic [1:0] {S_RUN, S_FAULT, S_HALT} state_t;

    localparam logic [LOG_FIFO_DEPTH:0]   DEPTH_C = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
    localparam logic [LOG_FIFO_DEPTH:0]   CNT_ONE = (LOG_FIFO_DEPTH+1)'(1);
    localparam logic [LOG_FIFO_DEPTH-1:0] PTR_ONE = LOG_FIFO_DEPTH'(1);
    localparam logic [ADDR_WIDTH-1:0]     PC_STEP = ADDR_WIDTH'(4);

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic [LOG_FIFO_DEPTH:0]   count_q, count_d;
    logic [LOG_FIFO_DEPTH-1:0] head_q, head_d;
    logic [LOG_FIFO_DEPTH-1:0] tail_q, tail_d;

    logic [INST_WIDTH-1:0] inst_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] epc_q   [FIFO_DEPTH];
    logic                  fault_q [FIFO_DEPTH];

    logic not_full;
    logic push_hit;
    logic push_fault;
    logic push;
    logic pop;

    // The reset gate keeps the Icache request low for the whole reset window.
    assign not_full      = (count_q < DEPTH_C);
    assign icache_enable = reset && (state_q == S_RUN) && not_full && !redirect_valid;
    assign fetch_addr    = pc_q;
    assign push_hit      = icache_enable && icache_valid;
    assign push_fault    = (state_q == S_FAULT) && not_full && !redirect_valid;
    assign push          = push_hit || push_fault;

    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid && dec_ready && !redirect_valid;
    assign dec_inst  = inst_q[head_q];
    assign dec_pc    = epc_q[head_q];
    assign dec_fault = fault_q[head_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (redirect_valid) begin
            // Flush wins over any same-cycle push or pop.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] == 2'b00) ? S_RUN : S_FAULT;
        end else begin
            if (push) tail_d = tail_q + PTR_ONE;
            if (pop)  head_d = head_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
            if (push_hit)   pc_d    = pc_q + PC_STEP;
            if (push_fault) state_d = S_HALT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Entry storage is cleared on reset so the decode outputs read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_q[i]  <= '0;
                epc_q[i]   <= '0;
                fault_q[i] <= 1'b0;
            end
        end else if (push) begin
            inst_q[tail_q]  <= push_fault ? '0 : icache_inst;
            epc_q[tail_q]   <= pc_q;
            fault_q[tail_q] <= push_fault;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked against a queue-based reference of the fetch front end.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_addr;
    logic        icache_enable;
    logic [31:0] icache_inst;
    logic        icache_valid;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [63:0] dec_pc;
    logic        dec_fault;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(
        .ADDR_WIDTH(64), .INST_WIDTH(32), .FIFO_DEPTH(2), .LOG_FIFO_DEPTH(1),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_addr(fetch_addr), .icache_enable(icache_enable),
        .icache_inst(icache_inst), .icache_valid(icache_valid),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_fault(dec_fault)
    );

    always #5 clk = ~clk;

    // Reference: ordered list of buffered entries, the fetch PC and a mode
    // (0 fetching, 1 owes a fault entry, 2 stopped until redirect).
    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_mode;

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RST_PC;
        m_mode = 0;
    endtask

    // Called just after a falling edge; applies one cycle of inputs.
    task automatic step(input logic rv, input logic [63:0] rpc, input logic iv,
                        input logic [31:0] ins, input logic rdy);
        int   sz;
        logic exp_en;
        ent_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_valid   = iv;
        icache_inst    = ins;
        dec_ready      = rdy;
        #1;
        sz     = mq.size();
        exp_en = (m_mode == 0) && (sz < 2) && !rv;
        chk64("icache_enable", 64'(icache_enable), 64'(exp_en));
        chk64("fetch_addr", fetch_addr, m_pc);
        chk64("dec_valid", 64'(dec_valid), 64'(sz > 0));
        if (sz > 0) begin
            chk64("dec_pc", dec_pc, mq[0].pc);
            chk64("dec_inst", 64'(dec_inst), 64'(mq[0].inst));
            chk64("dec_fault", 64'(dec_fault), 64'(mq[0].fault));
        end
        if (rv) begin
            mq.delete();
            m_pc   = rpc;
            m_mode = (rpc[1:0] == 2'b00) ? 0 : 1;
        end else begin
            if (sz > 0 && rdy) void'(mq.pop_front());
            if (exp_en && iv) begin
                e = '{inst: ins, pc: m_pc, fault: 1'b0};
                mq.push_back(e);
                m_pc = m_pc + 64'd4;
            end else if (m_mode == 1 && sz < 2) begin
                e = '{inst: 32'd0, pc: m_pc, fault: 1'b1};
                mq.push_back(e);
                m_mode = 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the outputs drop at once.
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        chk64("rst_icache_enable", 64'(icache_enable), 64'd0);
        chk64("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk64("rst_dec_pc", dec_pc, 64'd0);
        chk64("rst_dec_inst", 64'(dec_inst), 64'd0);
        chk64("rst_dec_fault", 64'(dec_fault), 64'd0);
        chk64("rst_fetch_addr", fetch_addr, RST_PC);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [63:0] rpc;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        icache_valid   = 1'b1;
        icache_inst    = 32'h0;
        dec_ready      = 1'b1;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Streaming with continuous hits and a ready decoder.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hA000_0000 + i, 1);

        // Back-pressure from a fresh start, then drain.
        pulse_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hB000_0000 + i, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hB100_0000 + i, 1);

        // Redirect colliding with a hit while one entry is buffered.
        pulse_reset();
        step(0, 0, 1, 32'hC000_0000, 0);
        step(1, 64'h2000, 1, 32'hC000_0001, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hC100_0000 + i, 1);

        // Misaligned target: one fault entry, then idle until redirect.
        step(1, 64'h2002, 1, 32'hD000_0000, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hD100_0000 + i, 1);
        step(1, 64'h3000, 1, 32'hD200_0000, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hD300_0000 + i, 1);

        // PC wrap at the top of the address space.
        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'hE000_0000, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hE100_0000 + i, 1);
        chk64("wrap_fetch_addr", fetch_addr, 64'h8);

        // Reset during a stall with two entries queued and a miss pending.
        step(1, 64'h4000, 1, 32'h0, 1);
        step(0, 0, 1, 32'hF000_0000, 0);
        step(0, 0, 1, 32'hF000_0001, 0);
        step(0, 0, 0, 32'hF000_0002, 0);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hF100_0000 + i, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rpc = {48'h0, 16'($urandom)};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step(($urandom_range(0, 15) == 0), rpc, 1'($urandom), $urandom, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
